// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Program-counter unit for a single-cycle MIPS datapath. It holds the PC
// register, works out the next PC from the decode-stage redirect requests
// (JR > J/JAL > taken branch > sequential), and converts the word-unit branch
// offset and jump index into byte addresses itself.
//
// A redirect that arrives while the pipeline is stalled is parked in a
// one-entry pending buffer. A later stalled redirect overwrites it. The parked
// target is applied on the first non-stalled cycle that has no fresh redirect.
//
// A JR target that is not word aligned is caught when it would be applied. On
// that cycle the PC holds, the sticky misaligned flag is set, and the unit
// enters HALT. An explicit halt request also enters HALT. Only reset leaves
// HALT.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hold the PC this cycle (redirects are parked)
//   branch_taken   conditional branch resolved taken
//   branch_offset  sign-extended immediate, in words
//   jump           J/JAL
//   jump_index     instruction[25:0]
//   jump_reg       JR/JALR
//   jump_reg_addr  byte target read from the register file
//   halt           stop fetching
//   pc             current PC (byte address)
//   pc_plus4       pc + 4, wraps at 2^32
//   imem_word_addr pc[IMEM_AW+1:2], the instruction-memory word index
//   misaligned     sticky: a JR target had addr[1:0] != 0
//   halted         unit is in the HALT state
//
// Every output depends only on registered state.
// -----------------------------------------------------------------------------
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               jump_reg,
    input  logic [31:0]        jump_reg_addr,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [IMEM_AW-1:0] imem_word_addr,
    output logic               misaligned,
    output logic               halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Registered state
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_is_jr_q, pend_is_jr_d;

    // Redirect decode
    logic [31:0] pc_plus4_s;
    logic        redirect_s;
    logic [31:0] redirect_target_s;
    logic        redirect_is_jr_s;

    // Target actually chosen in a non-stalled RUN cycle
    logic [31:0] sel_target_s;
    logic        sel_is_jr_s;

    // A JR target must be word aligned. Branch and jump targets are aligned
    // by construction, so only JR-sourced targets are checked.
    function automatic logic jr_target_bad(input logic is_jr, input logic [31:0] addr);
        return is_jr && (addr[1:0] != 2'b00);
    endfunction

    // Sequential address. The addition wraps from 32'hFFFF_FFFC to 0.
    assign pc_plus4_s = pc_q + 32'd4;

    // Pick the highest-priority redirect and compute its byte target.
    always_comb begin
        redirect_target_s = pc_plus4_s;
        redirect_is_jr_s  = 1'b0;
        redirect_s        = jump_reg | jump | branch_taken;
        if (jump_reg) begin
            redirect_target_s = jump_reg_addr;
            redirect_is_jr_s  = 1'b1;
        end else if (jump) begin
            redirect_target_s = {pc_plus4_s[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            // Offset is in words. Dropping its top two bits is the same as
            // wrapping the result modulo 2^32.
            redirect_target_s = pc_plus4_s + {branch_offset[29:0], 2'b00};
        end else begin
            redirect_target_s = pc_plus4_s;
        end
    end

    // Non-stalled choice: a fresh redirect, else the parked target, else sequential.
    always_comb begin
        sel_target_s = pc_plus4_s;
        sel_is_jr_s  = 1'b0;
        if (redirect_s) begin
            sel_target_s = redirect_target_s;
            sel_is_jr_s  = redirect_is_jr_s;
        end else if (pend_valid_q) begin
            sel_target_s = pend_target_q;
            sel_is_jr_s  = pend_is_jr_q;
        end else begin
            sel_target_s = pc_plus4_s;
            sel_is_jr_s  = 1'b0;
        end
    end

    // Next-state logic for the RUN/HALT controller, the PC and the pending buffer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misaligned_d  = misaligned_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_is_jr_d  = pend_is_jr_q;

        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    // PC holds. The latest stalled redirect replaces any parked one.
                    if (redirect_s) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target_s;
                        pend_is_jr_d  = redirect_is_jr_s;
                    end else begin
                        pend_valid_d  = pend_valid_q;
                    end
                    // halt wins over stall and throws away the parked redirect.
                    if (halt) begin
                        state_d      = ST_HALT;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d      = ST_RUN;
                    end
                end else begin
                    if (jr_target_bad(sel_is_jr_s, sel_target_s)) begin
                        // Never load a misaligned fetch address.
                        pc_d         = pc_q;
                        misaligned_d = 1'b1;
                        state_d      = ST_HALT;
                    end else begin
                        pc_d         = sel_target_s;
                        state_d      = halt ? ST_HALT : ST_RUN;
                    end
                    pend_valid_d = 1'b0;
                end
            end
            ST_HALT: begin
                // Frozen. Only reset leaves this state.
                state_d = ST_HALT;
            end
            default: begin
                // An illegal encoding falls into the safe, frozen state.
                state_d      = ST_HALT;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            misaligned_q  <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            pend_is_jr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misaligned_q  <= misaligned_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_is_jr_q  <= pend_is_jr_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_s;
    assign imem_word_addr = pc_q[IMEM_AW+1:2];
    assign misaligned     = misaligned_q;
    assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// Testbench for pc_next_unit.
//
// The driver applies inputs on the falling edge. It steps a behavioural model
// of the unit and pushes the expected post-edge state into a queue. A separate
// monitor wakes just after every rising edge, pops one entry and compares all
// outputs against it. Directed scenarios also check literal PC values.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IMEM_AW  = 8;

    logic               clk = 1'b0;
    logic               reset, stall, branch_taken, jump, jump_reg, halt;
    logic [31:0]        branch_offset, jump_reg_addr;
    logic [25:0]        jump_index;
    logic [31:0]        pc, pc_plus4;
    logic [IMEM_AW-1:0] imem_word_addr;
    logic               misaligned, halted;

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
        .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
        .imem_word_addr(imem_word_addr), .misaligned(misaligned), .halted(halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    logic [31:0] m_pc  = 32'h0;
    bit          m_mis = 1'b0, m_hlt = 1'b0, m_pv = 1'b0, m_pjr = 1'b0;
    logic [31:0] m_pt  = 32'h0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the current input values.
    task automatic model_step();
        logic [31:0] tgt, sel;
        bit          redir, tjr, sjr;
        if (reset) begin
            m_pc = RESET_PC; m_mis = 0; m_hlt = 0; m_pv = 0;
        end else if (!m_hlt) begin
            redir = jump_reg || jump || branch_taken;
            tjr   = 0;
            if (jump_reg) begin
                tgt = jump_reg_addr; tjr = 1;
            end else if (jump)
                tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
            else
                tgt = m_pc + 32'd4 + branch_offset * 32'd4;
            if (stall) begin
                if (redir) begin m_pt = tgt; m_pjr = tjr; m_pv = 1; end
                if (halt) begin m_hlt = 1; m_pv = 0; end
            end else begin
                if (redir) begin sel = tgt; sjr = tjr; end
                else if (m_pv) begin sel = m_pt; sjr = m_pjr; end
                else begin sel = m_pc + 32'd4; sjr = 0; end
                if (sjr && (sel % 32'd4) != 32'd0) begin
                    m_mis = 1; m_hlt = 1;
                end else begin
                    m_pc = sel;
                    if (halt) m_hlt = 1;
                end
                m_pv = 0;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit h,
                         input bit jr, input logic [31:0] ja,
                         input bit j, input logic [25:0] ji,
                         input bit br, input logic [31:0] off);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = st; halt = h;
        jump_reg = jr; jump_reg_addr = ja;
        jump = j; jump_index = ji;
        branch_taken = br; branch_offset = off;
        model_step();
        e.pc = m_pc; e.mis = m_mis; e.hlt = m_hlt;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    endtask

    // Wait until the cycle just driven has been clocked and has settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the DUT against the oldest expected state after each edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("sb_pc", pc, mon_e.pc);
            cmp("sb_pc_plus4", pc_plus4, mon_e.pc + 32'd4);
            cmp("sb_imem_word_addr", {24'd0, imem_word_addr}, (mon_e.pc >> 2) & 32'hFF);
            cmp("sb_misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
            cmp("sb_halted", {31'd0, halted}, {31'd0, mon_e.hlt});
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit          r_rst, r_st, r_h, r_jr, r_j, r_br;
        logic [31:0] r_ja, r_off;
        logic [25:0] r_ji;

        reset = 1; stall = 0; halt = 0; jump_reg = 0; jump = 0; branch_taken = 0;
        jump_reg_addr = 0; jump_index = 0; branch_offset = 0;

        // Reset, then free-running fetch
        drive(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0); settle();
        cmp("reset_pc", pc, 32'h0);
        cmp("reset_flags", {30'd0, misaligned, halted}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            idle(); settle();
            cmp("seq_pc", pc, 32'd4 * i);
            cmp("seq_imem", {24'd0, imem_word_addr}, i);
        end

        // Backward branch from 0x10 with an offset of -3 words
        drive(0, 0, 0, 1, 32'h10, 0, 26'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFD); settle();
        cmp("branch_neg", pc, 32'h8);

        // Jump beats a simultaneous branch
        drive(0, 0, 0, 1, 32'h4000_0000, 0, 26'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 1, 26'h000_0100, 1, 32'h10); settle();
        cmp("jump_prio", pc, 32'h4000_0400);

        // Stall three cycles: branch to 0x40, then jump to 0x80 (latest wins)
        drive(0, 0, 0, 1, 32'h0, 0, 26'h0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 26'h0, 1, 32'd15); settle();
        cmp("stall_hold1", pc, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 1, 26'h20, 0, 32'h0); settle();
        cmp("stall_hold2", pc, 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0); settle();
        cmp("stall_hold3", pc, 32'h0);
        idle(); settle();
        cmp("pending_apply", pc, 32'h80);

        // Misaligned JR: PC holds, sticky flag, HALT, inputs then ignored
        drive(0, 0, 0, 1, 32'h0000_0102, 0, 26'h0, 0, 32'h0); settle();
        cmp("mis_pc_hold", pc, 32'h80);
        cmp("mis_flags", {30'd0, misaligned, halted}, 32'h3);
        drive(0, 0, 0, 0, 32'h0, 1, 26'h40, 0, 32'h0); settle();
        cmp("halt_ignores", pc, 32'h80);
        drive(1, 1, 0, 1, 32'h3, 0, 26'h0, 0, 32'h0); settle();
        cmp("halt_reset_pc", pc, RESET_PC);
        cmp("halt_reset_flags", {30'd0, misaligned, halted}, 32'h0);

        // Wrap from the top of the address space, then halt while stalled
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0, 0, 32'h0);
        idle(); settle();
        cmp("wrap_pc", pc, 32'h0);
        drive(0, 1, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0); settle();
        cmp("halt_stall", {30'd0, misaligned, halted}, 32'h1);
        idle(); settle();
        cmp("halt_frozen", pc, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);

        // A misaligned JR parked during a stall is caught when applied
        drive(0, 1, 0, 1, 32'h0000_0103, 0, 26'h0, 0, 32'h0);
        idle(); settle();
        cmp("mis_pending", {30'd0, misaligned, halted}, 32'h3);
        cmp("mis_pending_pc", pc, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);

        // halt without stall: this cycle's update still happens
        idle();
        drive(0, 0, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0); settle();
        cmp("halt_update_pc", pc, 32'h8);
        idle(); settle();
        cmp("halt_update_frozen", pc, 32'h8);
        drive(1, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r_rst = m_hlt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_h   = ($urandom_range(0, 79) == 0);
            r_jr  = ($urandom_range(0, 7) == 0);
            r_ja  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) r_ja = r_ja | 32'($urandom_range(1, 3));
            r_j   = ($urandom_range(0, 7) == 0);
            r_ji  = 26'($urandom);
            r_br  = ($urandom_range(0, 3) == 0);
            r_off = 32'($urandom_range(0, 63)) - 32'd32;
            drive(r_rst, r_st, r_h, r_jr, r_ja, r_j, r_ji, r_br, r_off);
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
